// File: rtl/marmot_uart_pkg.sv
// Shared definitions for the Marmot UART receive and transmit paths.
package marmot_uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // 25 MHz system clock at 115200 baud gives 217 clocks per bit.
    localparam int CLK_HZ               = 25_000_000;
    localparam int BAUD_RATE            = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

    // Fast bit period used for short simulations and high-speed links.
    localparam int UART_HIGH_SPEED = 16;

endpackage

// File: rtl/marmot_uart_rx_fifo.sv
// Small circular byte FIFO with an explicit occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
// Otherwise the byte is dropped and reported on the dropped pulse.
module marmot_uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             dropped
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    // A simultaneous pop frees the slot that the push then takes.
    assign push_ok = push && (!full || pop_ok);
    assign dropped = push && full && !pop_ok;
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage. It is cleared on reset so that the head byte reads 8'h00 out of reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/marmot_uart_rx.sv
// 8N1 UART receiver with a byte FIFO, framing-error pulse and sticky overflow flag.
// Bits are sampled once at the nominal bit centre, which is half a bit after the start edge.
module marmot_uart_rx
    import marmot_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [CNT_W-1:0]     rx_count,
    output logic                 frame_err,
    output logic                 overflow,
    input  logic                 overflow_clr,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    logic                 sync1_reg;
    logic                 rxs;
    logic                 rxs_prev_reg;
    rx_state_t            state_reg;
    logic [BAUD_W-1:0]    baud_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 sample;
    logic                 push;
    logic                 fifo_empty;
    logic                 drop;

    // Two-flop synchronizer plus one history flop for start-edge detection.
    // All three flops reset to the idle line level.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_reg    <= 1'b1;
            rxs          <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= rxd;
            rxs          <= sync1_reg;
            rxs_prev_reg <= rxs;
        end
    end

    assign sample = (baud_cnt_reg == '0);
    // A good stop bit commits the assembled byte in the stop-sample cycle.
    assign push   = (state_reg == STOP) && sample && rxs;

    // Frame FSM with the baud counter, bit counter, shifter and registered status outputs.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rxs_prev_reg && !rxs) begin
                        state_reg    <= START;
                        baud_cnt_reg <= HALF_LOAD;
                        bit_cnt_reg  <= '0;
                        busy         <= 1'b1;
                    end
                end
                START: begin
                    if (!sample) begin
                        baud_cnt_reg <= baud_cnt_reg - BAUD_W'(1);
                    end else if (rxs) begin
                        // The line is high again at mid-start, so this was a glitch.
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        state_reg    <= DATA;
                        baud_cnt_reg <= FULL_LOAD;
                    end
                end
                DATA: begin
                    if (!sample) begin
                        baud_cnt_reg <= baud_cnt_reg - BAUD_W'(1);
                    end else begin
                        shift_reg    <= {rxs, shift_reg[DATA_BITS-1:1]};
                        baud_cnt_reg <= FULL_LOAD;
                        if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
                            state_reg <= STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (!sample) begin
                        baud_cnt_reg <= baud_cnt_reg - BAUD_W'(1);
                    end else if (rxs) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state_reg <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // Hold off through a break so a long low level cannot start a new frame.
                    if (rxs) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow. A new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    marmot_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rx_ready),
        .rd_data   (rx_data),
        .count     (rx_count),
        .empty     (fifo_empty),
        .dropped   (drop)
    );

    assign rx_valid = !fifo_empty;

endmodule
